// File: rtl/lif_membrane.sv
// Leaky-integrate-and-fire membrane stage.
// The block holds the membrane potential and presents its leaked value as `u`.
// On each enabled timestep it captures the normalised potential `u_bn` and
// decides whether to fire. Firing uses reset-by-subtraction, and after a spike
// the block counts down a refractory period.
module lif_membrane #(
  parameter int WIDTH            = 6,
  parameter int REFRACTORY_WIDTH = 4,
  parameter int COUNT_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic signed [WIDTH-1:0]     u_bn,
  input  logic        [WIDTH-2:0]     threshold,
  input  logic        [1:0]           leak_shift,
  input  logic [REFRACTORY_WIDTH-1:0] refractory_period,
  input  logic                        count_clear,
  output logic signed [WIDTH-1:0]     u,
  output logic signed [WIDTH-1:0]     membrane,
  output logic                        spike,
  output logic                        refractory,
  output logic [COUNT_WIDTH-1:0]      spike_count
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic signed [WIDTH-1:0]     state;
  logic [REFRACTORY_WIDTH-1:0] ref_cnt;
  logic signed [WIDTH-1:0]     leaked;
  logic signed [WIDTH-1:0]     shifted;
  logic signed [WIDTH-1:0]     thr_ext;
  logic                        idle;
  logic                        fire;

  // The threshold is unsigned, so zero-extend it to a non-negative signed value.
  assign thr_ext = {1'b0, threshold};

  // The refractory counter is zero, so the neuron can integrate or fire this timestep.
  assign idle    = (ref_cnt == '0);

  // Firing depends only on the registered counter and the current inputs.
  // The spike itself comes out of a register, so no output depends on u_bn combinationally.
  assign fire    = enable && idle && (u_bn >= thr_ext);

  // Leak: s - (s >>> k) lies between 0 and s, so it cannot overflow.
  // k = 0 needs its own case because s - (s >>> 0) would give 0, not s.
  always_comb begin
    shifted = state >>> leak_shift;
    leaked  = state;
    if (leak_shift != 2'd0) begin
      leaked = state - shifted;
    end
  end

  assign u          = leaked;
  assign membrane   = state;
  assign refractory = !idle;

  // Update the membrane and the refractory counter, and register the spike pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= '0;
      ref_cnt <= '0;
      spike   <= 1'b0;
    end else begin
      spike <= 1'b0;
      if (enable) begin
        if (!idle) begin
          // While refractory, u_bn is ignored and the membrane only leaks.
          state   <= leaked;
          ref_cnt <= ref_cnt - 1'b1;
        end else if (fire) begin
          // u_bn >= threshold >= 0 here, so the difference is non-negative.
          state   <= u_bn - thr_ext;
          ref_cnt <= refractory_period;
          spike   <= 1'b1;
        end else begin
          state <= u_bn;
        end
      end
    end
  end

  // Saturating spike counter; a clear takes priority over a simultaneous spike.
  always_ff @(posedge clk) begin
    if (reset || count_clear) begin
      spike_count <= '0;
    end else if (fire && (spike_count != COUNT_MAX)) begin
      spike_count <= spike_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lif_membrane.sv
// Directed-vector bench for lif_membrane with hand-computed expectations.
module tb_lif_membrane;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic signed [5:0] u_bn;
  logic [4:0]        threshold;
  logic [1:0]        leak_shift;
  logic [3:0]        refractory_period;
  logic              count_clear;
  logic signed [5:0] u;
  logic signed [5:0] membrane;
  logic              spike;
  logic              refractory;
  logic [7:0]        spike_count;

  int n_vectors     = 0;
  int n_miscompares = 0;

  lif_membrane #(.WIDTH(6), .REFRACTORY_WIDTH(4), .COUNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .u_bn(u_bn),
    .threshold(threshold), .leak_shift(leak_shift),
    .refractory_period(refractory_period), .count_clear(count_clear),
    .u(u), .membrane(membrane), .spike(spike), .refractory(refractory),
    .spike_count(spike_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and count the result.
  task automatic check_eq(input string tag, input int observed, input int expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs are driven after a negedge; one posedge then lands on the next negedge,
  // which is where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one enabled timestep with the given u_bn.
  task automatic step(input int value);
    enable = 1'b1;
    u_bn   = 6'(value);
    tick();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; u_bn = 6'sd20; threshold = 5'd10;
    leak_shift = 2'd0; refractory_period = 4'd0; count_clear = 1'b0;

    // Reset held for two cycles with enable and u_bn active.
    tick(); tick();
    check_eq("rst_membrane", membrane, 0);
    check_eq("rst_u", u, 0);
    check_eq("rst_spike", spike, 0);
    check_eq("rst_refractory", refractory, 0);
    check_eq("rst_count", spike_count, 0);

    // First enable after release: no fire, the membrane captures u_bn.
    reset = 1'b0;
    step(5);
    check_eq("first_membrane", membrane, 5);
    check_eq("first_spike", spike, 0);

    // Fire with reset-by-subtraction.
    step(13);
    check_eq("fire_spike", spike, 1);
    check_eq("fire_membrane", membrane, 3);
    check_eq("fire_u", u, 3);
    check_eq("fire_count", spike_count, 1);
    enable = 1'b0; tick();
    check_eq("fire_pulse_end", spike, 0);
    check_eq("fire_hold", membrane, 3);
    step(10);
    check_eq("fire_eq_spike", spike, 1);
    check_eq("fire_eq_membrane", membrane, 0);
    check_eq("fire_eq_count", spike_count, 2);

    // Leak.
    threshold = 5'd31; leak_shift = 2'd2;
    step(20);
    check_eq("leak_pos_spike", spike, 0);
    check_eq("leak_pos_membrane", membrane, 20);
    check_eq("leak_pos_u", u, 15);
    step(-20);
    check_eq("leak_neg_u", u, -15);
    leak_shift = 2'd1;
    step(-32);
    check_eq("leak_min_u", u, -16);
    step(-1);
    check_eq("leak_m1_u", u, 0);

    // Refractory.
    threshold = 5'd10; refractory_period = 4'd2; leak_shift = 2'd1;
    step(12);
    check_eq("ref_spike", spike, 1);
    check_eq("ref_membrane", membrane, 2);
    check_eq("ref_flag", refractory, 1);
    check_eq("ref_count", spike_count, 3);
    step(31);
    check_eq("ref1_spike", spike, 0);
    check_eq("ref1_membrane", membrane, 1);
    check_eq("ref1_flag", refractory, 1);
    enable = 1'b0; tick();
    check_eq("ref_idle_membrane", membrane, 1);
    check_eq("ref_idle_flag", refractory, 1);
    step(31);
    check_eq("ref2_spike", spike, 0);
    check_eq("ref2_membrane", membrane, 1);
    check_eq("ref2_flag", refractory, 0);
    step(31);
    check_eq("ref3_spike", spike, 1);
    check_eq("ref3_membrane", membrane, 21);
    check_eq("ref3_flag", refractory, 1);
    check_eq("ref3_count", spike_count, 4);
    // A period change mid-refractory does not reload the counter.
    refractory_period = 4'd0;
    step(0);
    check_eq("drain1_membrane", membrane, 11);
    check_eq("drain1_flag", refractory, 1);
    step(0);
    check_eq("drain2_membrane", membrane, 6);
    check_eq("drain2_flag", refractory, 0);
    check_eq("drain2_count", spike_count, 4);

    // Counter: clear, then saturate.
    count_clear = 1'b1; enable = 1'b0; tick();
    check_eq("clear_count", spike_count, 0);
    count_clear = 1'b0; threshold = 5'd1; refractory_period = 4'd0;
    for (int i = 0; i < 260; i++) begin
      step(5);
    end
    check_eq("sat_count", spike_count, 255);
    check_eq("sat_spike", spike, 1);
    check_eq("sat_membrane", membrane, 4);
    count_clear = 1'b1;
    step(5);
    check_eq("clear_prio_count", spike_count, 0);
    check_eq("clear_prio_spike", spike, 1);
    count_clear = 1'b0;

    // Reset asserted while refractory.
    refractory_period = 4'd3;
    step(7);
    check_eq("pre_rst_flag", refractory, 1);
    check_eq("pre_rst_count", spike_count, 1);
    reset = 1'b1; count_clear = 1'b0;
    step(7);
    check_eq("mid_rst_flag", refractory, 0);
    check_eq("mid_rst_membrane", membrane, 0);
    check_eq("mid_rst_spike", spike, 0);
    check_eq("mid_rst_count", spike_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
